// File: rtl/ps2_device.sv
// PS/2 device-side port: generates the PS/2 clock, sends bytes to the host,
// honours host inhibit / request-to-send and receives host bytes with ack.
// Optional build macro: PS2_DEV_PARITY_CHK_EN (parity/stop checking, errored
// frames are not delivered). Without it rx_err is tied 0 and every frame is delivered.
module ps2_device #(
    parameter int unsigned CLK_HALF    = 2500,
    parameter int unsigned INHIBIT_MIN = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    input  logic       wr_ps2,
    input  logic [7:0] tx_data,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic [7:0] rx_data,
    output logic       rx_done_tick,
    output logic       rx_err
);

    typedef enum logic [2:0] {StIdle, StTx, StInhibit, StRxWait, StRx, StRxAck} state_e;

    state_e      r_state;
    logic        r_c_meta, r_c_sync, r_d_meta, r_d_sync;
    logic [31:0] r_cnt;
    logic        r_half;      // 0 = released (high) half, 1 = driven-low half
    logic [3:0]  r_bit;
    logic [10:0] r_tx_shift;  // {stop, parity, data, start}; bit 0 is on the line
    logic [7:0]  r_rx_shift;
    logic        r_c_oe, r_d_oe, r_tx_done, r_rx_done;
    logic [7:0]  r_rx_data;
`ifdef PS2_DEV_PARITY_CHK_EN
    logic        r_rx_par, r_rx_stop, r_rx_err;
    logic        w_frame_err;

    // Odd parity over data+parity, and a stop bit of 1, make a good frame.
    assign w_frame_err = ~(^{r_rx_par, r_rx_shift}) | ~r_rx_stop;
    assign rx_err      = r_rx_err;
`else
    assign rx_err      = 1'b0;
`endif

    assign ps2c_oe      = r_c_oe;
    assign ps2d_oe      = r_d_oe;
    assign tx_done_tick = r_tx_done;
    assign rx_done_tick = r_rx_done;
    assign rx_data      = r_rx_data;
    assign tx_idle      = (r_state == StIdle) && r_c_sync;

    // Two-flop synchronizers for the bidirectional lines; reset to idle-high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c_meta <= 1'b1;
            r_c_sync <= 1'b1;
            r_d_meta <= 1'b1;
            r_d_sync <= 1'b1;
        end else begin
            r_c_meta <= ps2c_in;
            r_c_sync <= r_c_meta;
            r_d_meta <= ps2d_in;
            r_d_sync <= r_d_meta;
        end
    end

    // Main protocol FSM with registered line drivers and ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_half     <= 1'b0;
            r_bit      <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_c_oe     <= 1'b0;
            r_d_oe     <= 1'b0;
            r_tx_done  <= 1'b0;
            r_rx_done  <= 1'b0;
            r_rx_data  <= 8'h00;
`ifdef PS2_DEV_PARITY_CHK_EN
            r_rx_par   <= 1'b0;
            r_rx_stop  <= 1'b0;
            r_rx_err   <= 1'b0;
`endif
        end else begin
            r_tx_done <= 1'b0;
            r_rx_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_c_oe <= 1'b0;
                    r_d_oe <= 1'b0;
                    r_cnt  <= '0;
                    r_half <= 1'b0;
                    r_bit  <= '0;
                    if (!r_c_sync) begin
                        r_state <= StInhibit;
                    end else if (wr_ps2) begin
                        r_tx_shift <= {1'b1, ~^tx_data, tx_data, 1'b0};
                        r_d_oe     <= 1'b1;  // start bit
                        r_state    <= StTx;
                    end
                end
                StTx: begin
                    // Skip the first cycles of a high half: the synchronizer still shows our own low.
                    if (!r_half && (r_cnt >= 32'd2) && !r_c_sync) begin
                        r_c_oe  <= 1'b0;
                        r_d_oe  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= StInhibit;
                    end else if (r_cnt == CLK_HALF - 1) begin
                        r_cnt <= '0;
                        if (!r_half) begin
                            r_half <= 1'b1;
                            r_c_oe <= 1'b1;
                        end else begin
                            r_half <= 1'b0;
                            r_c_oe <= 1'b0;
                            if (r_bit == 4'd10) begin
                                r_d_oe    <= 1'b0;
                                r_tx_done <= 1'b1;
                                r_state   <= StIdle;
                            end else begin
                                r_bit      <= r_bit + 4'd1;
                                r_tx_shift <= {1'b1, r_tx_shift[10:1]};
                                r_d_oe     <= ~r_tx_shift[1];
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                StInhibit: begin
                    r_c_oe <= 1'b0;
                    r_d_oe <= 1'b0;
                    if (!r_c_sync) begin
                        if (r_cnt != '1) r_cnt <= r_cnt + 32'd1;
                    end else begin
                        r_cnt <= '0;
                        if ((r_cnt >= INHIBIT_MIN) && !r_d_sync) r_state <= StRxWait;
                        else                                     r_state <= StIdle;
                    end
                end
                StRxWait: begin
                    r_c_oe <= 1'b0;
                    r_d_oe <= 1'b0;
                    if (r_cnt == CLK_HALF - 1) begin
                        r_cnt   <= '0;
                        r_half  <= 1'b0;
                        r_bit   <= '0;
                        r_state <= StRx;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                StRx: begin
                    if (r_cnt == CLK_HALF - 1) begin
                        r_cnt <= '0;
                        if (!r_half) begin
                            r_half <= 1'b1;
                            r_c_oe <= 1'b1;
                        end else begin
                            // Rising clock edge: sample the host's bit.
                            r_half <= 1'b0;
                            r_c_oe <= 1'b0;
                            if (r_bit < 4'd8) r_rx_shift <= {r_d_sync, r_rx_shift[7:1]};
`ifdef PS2_DEV_PARITY_CHK_EN
                            else if (r_bit == 4'd8) r_rx_par <= r_d_sync;
                            else                    r_rx_stop <= r_d_sync;
`endif
                            if (r_bit == 4'd9) begin
                                r_bit   <= '0;
                                r_d_oe  <= 1'b1;  // ack
                                r_state <= StRxAck;
                            end else begin
                                r_bit <= r_bit + 4'd1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                StRxAck: begin
                    if (r_cnt == CLK_HALF - 1) begin
                        r_cnt <= '0;
                        if (!r_half) begin
                            r_half <= 1'b1;
                            r_c_oe <= 1'b1;
                        end else begin
                            r_half  <= 1'b0;
                            r_c_oe  <= 1'b0;
                            r_d_oe  <= 1'b0;
                            r_state <= StIdle;
`ifdef PS2_DEV_PARITY_CHK_EN
                            r_rx_err <= w_frame_err;
                            if (!w_frame_err) begin
                                r_rx_data <= r_rx_shift;
                                r_rx_done <= 1'b1;
                            end
`else
                            r_rx_data <= r_rx_shift;
                            r_rx_done <= 1'b1;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                    r_c_oe  <= 1'b0;
                    r_d_oe  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_device.sv
// Directed bench for ps2_device: table-driven device-send and host-send frames,
// plus hand-written abort, short-inhibit and mid-frame reset sequences.
module tb_ps2_device;

    localparam int unsigned CH = 6;
    localparam int unsigned IM = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       host_c_low = 1'b0;
    logic       host_d_low = 1'b0;
    logic       wr_ps2 = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, rx_done_tick, rx_err;
    logic [7:0] rx_data;
    logic       ps2c_line, ps2d_line;

    // Open-drain lines with pull-ups.
    assign ps2c_line = ~(ps2c_oe | host_c_low);
    assign ps2d_line = ~(ps2d_oe | host_d_low);

    ps2_device #(.CLK_HALF(CH), .INHIBIT_MIN(IM)) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2c_in      (ps2c_line),
        .ps2d_in      (ps2d_line),
        .ps2c_oe      (ps2c_oe),
        .ps2d_oe      (ps2d_oe),
        .wr_ps2       (wr_ps2),
        .tx_data      (tx_data),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .rx_err       (rx_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_txd   = 0;
    int n_rxd   = 0;

    always @(posedge clk) begin
        if (tx_done_tick) n_txd <= n_txd + 1;
        if (rx_done_tick) n_rxd <= n_rxd + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Device send; host samples data on each clock fall.
    task automatic tx_frame(input logic [7:0] d, input bit mid_wr, output logic [10:0] bits,
                            output int nfall, output int ndone);
        int   base;
        int   cyc;
        logic prev_c;
        bits  = '0;
        nfall = 0;
        base  = n_txd;
        @(negedge clk);
        tx_data = d;
        wr_ps2  = 1'b1;
        @(negedge clk);
        wr_ps2  = 1'b0;
        tx_data = 8'h00;
        check("tx_idle_busy", 32'(tx_idle), 32'd0);
        prev_c = ps2c_line;
        cyc    = 0;
        while (n_txd == base && cyc < 400) begin
            @(negedge clk);
            cyc++;
            wr_ps2 = 1'b0;
            if (prev_c && !ps2c_line) begin
                if (nfall < 11) bits[nfall] = ps2d_line;
                nfall++;
                if (mid_wr && nfall == 3) begin
                    tx_data = 8'h3C;
                    wr_ps2  = 1'b1;
                end
            end
            prev_c = ps2c_line;
        end
        repeat (4) @(negedge clk);
        ndone = n_txd - base;
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while (!tx_idle && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check(name, 32'(tx_idle), 32'd1);
    endtask

    // Host send: request-to-send, then change data on each device clock fall.
    task automatic host_send(input logic [7:0] d, input logic par, input logic stop,
                             output logic ack, output int nfall);
        logic [9:0] bits;
        logic       prev_c;
        int         cyc;
        bits  = {stop, par, d};
        ack   = 1'b0;
        nfall = 0;
        @(negedge clk);
        host_c_low = 1'b1;
        repeat (IM + IM / 5) @(negedge clk);
        host_d_low = 1'b1;
        repeat (2) @(negedge clk);
        host_c_low = 1'b0;
        prev_c = ps2c_line;
        cyc    = 0;
        while (nfall < 11 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (prev_c && !ps2c_line) begin
                if (nfall < 10) begin
                    host_d_low = ~bits[nfall];
                end else begin
                    ack        = ps2d_oe;
                    host_d_low = 1'b0;
                end
                nfall++;
            end
            prev_c = ps2c_line;
        end
        repeat (2 * CH + 6) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;   // {stop, parity, data, start}
        bit          mid_wr;
    } tx_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_done;
    } rx_vec_t;

    tx_vec_t tv[5];
    rx_vec_t rv[5];

    initial begin
        logic [10:0] bits;
        int          nfall, ndone, base_t, base_r, cyc;
        logic        ack, seen_c;

        tv[0] = '{data: 8'h1C, frame: 11'h438, mid_wr: 1'b0};
        tv[1] = '{data: 8'hAA, frame: 11'h754, mid_wr: 1'b0};
        tv[2] = '{data: 8'h00, frame: 11'h600, mid_wr: 1'b0};
        tv[3] = '{data: 8'hFF, frame: 11'h7FE, mid_wr: 1'b1};
        tv[4] = '{data: 8'h01, frame: 11'h402, mid_wr: 1'b0};

        // 0xED has six ones, so a good odd-parity frame carries parity 1.
        rv[0] = '{8'hF4, 1'b0, 1'b1, 8'hF4, 1'b0, 1};
        rv[2] = '{8'hED, 1'b1, 1'b1, 8'hED, 1'b0, 1};
        rv[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1};
`ifdef PS2_DEV_PARITY_CHK_EN
        rv[1] = '{8'hED, 1'b0, 1'b1, 8'hF4, 1'b1, 0};
        rv[3] = '{8'h55, 1'b1, 1'b0, 8'hED, 1'b1, 0};
`else
        rv[1] = '{8'hED, 1'b0, 1'b1, 8'hED, 1'b0, 1};
        rv[3] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b0, 1};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_c_oe", 32'(ps2c_oe), 32'd0);
        check("rst_d_oe", 32'(ps2d_oe), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_tx_done", 32'(tx_done_tick), 32'd0);
        check("rst_rx_done", 32'(rx_done_tick), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_err", 32'(rx_err), 32'd0);
        check("rst_tx_idle", 32'(tx_idle), 32'd1);

        // Device-to-host frames
        for (int i = 0; i < 5; i++) begin
            tx_frame(tv[i].data, tv[i].mid_wr, bits, nfall, ndone);
            check($sformatf("tx_frame[%0d]", i), 32'(bits), 32'(tv[i].frame));
            check($sformatf("tx_falls[%0d]", i), 32'(nfall), 32'd11);
            check($sformatf("tx_done[%0d]", i), 32'(ndone), 32'd1);
            wait_idle($sformatf("tx_idle_after[%0d]", i));
        end

        // Host-to-device frames
        for (int i = 0; i < 5; i++) begin
            base_r = n_rxd;
            host_send(rv[i].data, rv[i].par, rv[i].stop, ack, nfall);
            check($sformatf("rx_ack[%0d]", i), 32'(ack), 32'd1);
            check($sformatf("rx_falls[%0d]", i), 32'(nfall), 32'd11);
            check($sformatf("rx_done[%0d]", i), 32'(n_rxd - base_r), 32'(rv[i].exp_done));
            check($sformatf("rx_data[%0d]", i), 32'(rx_data), 32'(rv[i].exp_data));
            check($sformatf("rx_err[%0d]", i), 32'(rx_err), 32'(rv[i].exp_err));
            check($sformatf("rx_d_rel[%0d]", i), 32'(ps2d_oe), 32'd0);
        end

        // Abort during data bit 4 of 0xAA, then a host byte 0xF4
        wait_idle("abort_pre_idle");
        base_t = n_txd;
        @(negedge clk);
        tx_data = 8'hAA;
        wr_ps2  = 1'b1;
        @(negedge clk);
        wr_ps2  = 1'b0;
        nfall   = 0;
        cyc     = 0;
        seen_c  = ps2c_line;
        while (nfall < 5 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (seen_c && !ps2c_line) nfall++;
            seen_c = ps2c_line;
        end
        while (!ps2c_line && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_wait", 32'(cyc < 300), 32'd1);
        repeat (2) @(negedge clk);
        check("abort_pre_d_oe", 32'(ps2d_oe), 32'd1);
        host_c_low = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_c_rel", 32'(ps2c_oe), 32'd0);
        check("abort_d_rel", 32'(ps2d_oe), 32'd0);
        repeat (4 * CH) @(negedge clk);
        check("abort_no_done", 32'(n_txd - base_t), 32'd0);
        base_r = n_rxd;
        host_send(8'hF4, 1'b0, 1'b1, ack, nfall);
        check("abort_rx_ack", 32'(ack), 32'd1);
        check("abort_rx_done", 32'(n_rxd - base_r), 32'd1);
        check("abort_rx_data", 32'(rx_data), 32'hF4);

        // Short inhibit with data high: no RX, then a normal send
        @(negedge clk);
        host_c_low = 1'b1;
        repeat (IM * 2 / 5) @(negedge clk);
        host_c_low = 1'b0;
        base_r = n_rxd;
        seen_c = 1'b0;
        repeat (4 * CH) begin
            @(negedge clk);
            if (ps2c_oe) seen_c = 1'b1;
        end
        check("short_inh_no_clk", 32'(seen_c), 32'd0);
        check("short_inh_no_rx", 32'(n_rxd - base_r), 32'd0);
        check("short_inh_idle", 32'(tx_idle), 32'd1);
        tx_frame(8'h1C, 1'b0, bits, nfall, ndone);
        check("short_inh_frame", 32'(bits), 32'h438);
        check("short_inh_done", 32'(ndone), 32'd1);
        wait_idle("short_inh_idle_after");

        // Reset mid-TX
        base_t = n_txd;
        base_r = n_rxd;
        @(negedge clk);
        tx_data = 8'h00;
        wr_ps2  = 1'b1;
        @(negedge clk);
        wr_ps2  = 1'b0;
        nfall   = 0;
        cyc     = 0;
        seen_c  = ps2c_line;
        while (nfall < 4 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (seen_c && !ps2c_line) nfall++;
            seen_c = ps2c_line;
        end
        check("rst_mid_wait", 32'(cyc < 300), 32'd1);
        check("rst_mid_pre_c", 32'(ps2c_oe), 32'd1);
        check("rst_mid_pre_d", 32'(ps2d_oe), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_c_rel", 32'(ps2c_oe), 32'd0);
        check("rst_mid_d_rel", 32'(ps2d_oe), 32'd0);
        @(negedge clk);
        check("rst_mid_rx_data", 32'(rx_data), 32'h00);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_no_tx_tick", 32'(n_txd - base_t), 32'd0);
        check("rst_mid_no_rx_tick", 32'(n_rxd - base_r), 32'd0);
        tx_frame(8'h1C, 1'b0, bits, nfall, ndone);
        check("rst_mid_frame", 32'(bits), 32'h438);
        check("rst_mid_falls", 32'(nfall), 32'd11);
        check("rst_mid_done", 32'(ndone), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
